// File: rtl/dual_eye_fetch_scheduler.sv
// Line-fetch scheduler for a dual-eye (A/B alternating) frame buffer.
// Each frame it arms on the SYNC_V fall and picks the eye buffer. It then
// issues one req/ack/done fetch per line, running at most two lines ahead of
// the lines shown. If DE rises before its line has arrived, it flags an underrun.
module dual_eye_fetch_scheduler #(
  parameter int unsigned       HAPIX      = 800,
  parameter int unsigned       VAPIX      = 600,
  parameter int unsigned       LINE_WORDS = HAPIX / 4,
  parameter int unsigned       ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] BASE_A     = 24'h000000,
  parameter logic [ADDR_W-1:0] BASE_B     = 24'h020000
) (
  input  logic              clock_pixel,
  input  logic              reset,
  input  logic              HDMI_START,
  input  logic              SYNC_V,
  input  logic              DE,
  input  logic              oRequest,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  input  logic              fetch_done,
  output logic              eye_sel,
  output logic              running,
  output logic              underrun,
  output logic [7:0]        underrun_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_READY,
    S_REQ,
    S_BUSY
  } state_t;

  localparam logic [9:0]        VAPIX_C = 10'(VAPIX);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_WORDS);

  state_t              state_q, state_d;
  logic                pending_q, pending_d;
  logic                sync_v_q, sync_v_d;
  logic                de_q, de_d;
  logic [9:0]          fetched_q, fetched_d;
  logic [9:0]          shown_q, shown_d;
  logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
  logic                fetch_req_q, fetch_req_d;
  logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic                eye_sel_q, eye_sel_d;
  logic                running_q, running_d;
  logic                underrun_q, underrun_d;
  logic [7:0]          underrun_cnt_q, underrun_cnt_d;

  logic                frame_start;
  logic                de_rise;
  logic                de_fall;
  logic [9:0]          ahead;

  assign frame_start = sync_v_q & ~SYNC_V;
  assign de_rise     = DE & ~de_q;
  assign de_fall     = ~DE & de_q;
  // Lines buffered but not yet shown; clamps at zero while an underrun has
  // let the display overtake the fetcher.
  assign ahead       = (fetched_q >= shown_q) ? (fetched_q - shown_q) : 10'd0;

  // Next-state, counters and registered-output values.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave
    // one unassigned and infer a latch.
    state_d        = state_q;
    pending_d      = pending_q;
    sync_v_d       = SYNC_V;
    de_d           = DE;
    fetched_d      = fetched_q;
    shown_d        = shown_q;
    line_addr_d    = line_addr_q;
    fetch_req_d    = fetch_req_q;
    fetch_addr_d   = fetch_addr_q;
    eye_sel_d      = eye_sel_q;
    underrun_d     = underrun_q;
    underrun_cnt_d = underrun_cnt_q;

    if (running_q && de_fall && (shown_q < VAPIX_C)) begin
      shown_d = shown_q + 10'd1;
    end

    if (running_q && de_rise && (fetched_q <= shown_q)) begin
      underrun_d = 1'b1;
      if (underrun_cnt_q != 8'hFF) begin
        underrun_cnt_d = underrun_cnt_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start && HDMI_START) begin
          state_d   = S_ARM;
          eye_sel_d = 1'b0;
        end
      end

      S_ARM: begin
        fetched_d   = 10'd0;
        shown_d     = 10'd0;
        pending_d   = 1'b0;
        line_addr_d = eye_sel_q ? BASE_B : BASE_A;
        state_d     = S_READY;
      end

      S_READY: begin
        if (frame_start) begin
          if (HDMI_START) begin
            state_d   = S_ARM;
            eye_sel_d = ~eye_sel_q;
          end else begin
            state_d = S_IDLE;
          end
        end else if (oRequest && (fetched_q < VAPIX_C) && (ahead < 10'd2)) begin
          state_d      = S_REQ;
          fetch_req_d  = 1'b1;
          fetch_addr_d = line_addr_q;
        end
      end

      S_REQ: begin
        if (frame_start) begin
          pending_d = 1'b1;
        end
        if (fetch_ack) begin
          fetch_req_d = 1'b0;
          state_d     = S_BUSY;
        end
      end

      S_BUSY: begin
        if (frame_start) begin
          pending_d = 1'b1;
        end
        if (fetch_done) begin
          fetched_d   = fetched_q + 10'd1;
          line_addr_d = line_addr_q + LINE_STEP;
          // A frame start seen during the handshake is honoured only now,
          // after the in-flight line has been counted.
          if (pending_q || frame_start) begin
            pending_d = 1'b0;
            if (HDMI_START) begin
              state_d   = S_ARM;
              eye_sel_d = ~eye_sel_q;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_READY;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    running_d = (state_d != S_IDLE);
  end

  // State and output registers; async reset aborts any transaction in flight.
  always_ff @(posedge clock_pixel or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pending_q      <= 1'b0;
      sync_v_q       <= 1'b1;
      de_q           <= 1'b0;
      fetched_q      <= 10'd0;
      shown_q        <= 10'd0;
      line_addr_q    <= '0;
      fetch_req_q    <= 1'b0;
      fetch_addr_q   <= '0;
      eye_sel_q      <= 1'b0;
      running_q      <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      pending_q      <= pending_d;
      sync_v_q       <= sync_v_d;
      de_q           <= de_d;
      fetched_q      <= fetched_d;
      shown_q        <= shown_d;
      line_addr_q    <= line_addr_d;
      fetch_req_q    <= fetch_req_d;
      fetch_addr_q   <= fetch_addr_d;
      eye_sel_q      <= eye_sel_d;
      running_q      <= running_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign fetch_req    = fetch_req_q;
  assign fetch_addr   = fetch_addr_q;
  assign eye_sel      = eye_sel_q;
  assign running      = running_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule
